// File: rtl/aes_ttable_pipe_pkg.sv
// Shared AES constants for the T-table pipeline: S-boxes, GF(2^8) helpers, word type.
package aes_pkg;

    localparam logic [8:0] AES_POLY = 9'h11b;

    typedef logic [31:0] word_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY[7:0] : 8'h00);
    endfunction

    // Constant multiplier; c is a literal at every call site so this folds to an XOR network.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [7:0] c);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = b;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic word_t rotr_word(input word_t w, input int unsigned n);
        logic [63:0] dbl;
        dbl = {w, w};
        return 32'(dbl >> n);
    endfunction

endpackage

// File: rtl/aes_ttable_pipe_if.sv
// Valid/ready bus for aes_ttable_pipe; in_final exists only with AES_TTAB_FINAL_EN defined.
interface aes_ttable_pipe_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned SW = 32 * LANES;
    localparam int unsigned PW = 128 * LANES;

    logic             in_valid;
    logic             in_ready;
    logic [SW-1:0]    in_state;
    logic             in_dec;
    logic [TAG_W-1:0] in_tag;
`ifdef AES_TTAB_FINAL_EN
    logic             in_final;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [PW-1:0]    out_p;
    logic             out_dec;
    logic [TAG_W-1:0] out_tag;

`ifdef AES_TTAB_FINAL_EN
    modport master (output in_valid, in_state, in_dec, in_tag, in_final, out_ready,
                    input  in_ready, out_valid, out_p, out_dec, out_tag);
    modport slave  (input  in_valid, in_state, in_dec, in_tag, in_final, out_ready,
                    output in_ready, out_valid, out_p, out_dec, out_tag);
`else
    modport master (output in_valid, in_state, in_dec, in_tag, out_ready,
                    input  in_ready, out_valid, out_p, out_dec, out_tag);
    modport slave  (input  in_valid, in_state, in_dec, in_tag, out_ready,
                    output in_ready, out_valid, out_p, out_dec, out_tag);
`endif

endinterface

// File: rtl/aes_ttable_pipe_lane.sv
// One lane: stage 1 latches S/InvS of each byte, stage 2 forms and rotates the four T-words.
module aes_ttable_lane
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s1_en_i,
    input  logic         s2_en_i,
    input  word_t        word_i,
    input  logic         dec_i,
    input  logic         s1_dec_i,
    input  logic         s1_final_i,
    output logic [127:0] p_o
);
    logic [127:0] p_d;
    logic [127:0] p_q;

    for (genvar k = 0; k < 4; k++) begin : g_byte
        logic [7:0] b_c;
        logic [7:0] sub_d;
        logic [7:0] sub_q;
        word_t      t_c;

        assign b_c   = word_i[31-8*k -: 8];
        assign sub_d = dec_i ? INV_SBOX[b_c] : SBOX[b_c];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       sub_q <= 8'h00;
            else if (s1_en_i) sub_q <= sub_d;
        end

        // Final round bypasses MixColumns: only the substituted byte survives.
        always_comb begin
            t_c = {sub_q, sub_q, gf_mul_const(sub_q, 8'h03), gf_mul_const(sub_q, 8'h02)};
            if (s1_final_i) begin
                t_c = {24'h000000, sub_q};
            end else if (s1_dec_i) begin
                t_c = {gf_mul_const(sub_q, 8'h0e), gf_mul_const(sub_q, 8'h09),
                       gf_mul_const(sub_q, 8'h0d), gf_mul_const(sub_q, 8'h0b)};
            end
        end

        assign p_d[32*(3-k) +: 32] = rotr_word(t_c, 8 * ((k + 1) % 4));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       p_q <= '0;
        else if (s2_en_i) p_q <= p_d;
    end

    assign p_o = p_q;

endmodule

// File: rtl/aes_ttable_pipe.sv
// Two-stage handshaked AES T-table lookup over LANES words.
// Optional AES_TTAB_FINAL_EN adds in_final (SubBytes-only final round).
module aes_ttable_pipe
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned TAG_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    aes_ttable_pipe_if.slave bus
);
    logic             adv_c;
    logic             ld1_c;
    logic             ld2_c;
    logic             final_c;

    logic             s1_valid_d, s1_valid_q;
    logic             s1_dec_d,   s1_dec_q;
    logic             s1_final_d, s1_final_q;
    logic [TAG_W-1:0] s1_tag_d,   s1_tag_q;
    logic             out_valid_d, out_valid_q;
    logic             out_dec_d,   out_dec_q;
    logic [TAG_W-1:0] out_tag_d,   out_tag_q;

`ifdef AES_TTAB_FINAL_EN
    assign final_c = bus.in_final;
`else
    assign final_c = 1'b0;
`endif

    // Whole pipe moves together; a held output freezes both stages.
    assign adv_c        = !out_valid_q || bus.out_ready;
    assign ld1_c        = bus.in_valid && adv_c;
    assign ld2_c        = s1_valid_q && adv_c;
    assign bus.in_ready = adv_c;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_dec_d    = s1_dec_q;
        s1_final_d  = s1_final_q;
        s1_tag_d    = s1_tag_q;
        out_valid_d = out_valid_q;
        out_dec_d   = out_dec_q;
        out_tag_d   = out_tag_q;
        if (adv_c) begin
            s1_valid_d  = bus.in_valid;
            out_valid_d = s1_valid_q;
        end
        if (ld1_c) begin
            s1_dec_d   = bus.in_dec;
            s1_final_d = final_c;
            s1_tag_d   = bus.in_tag;
        end
        if (ld2_c) begin
            out_dec_d = s1_dec_q;
            out_tag_d = s1_tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_dec_q    <= 1'b0;
            s1_final_q  <= 1'b0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_dec_q   <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_dec_q    <= s1_dec_d;
            s1_final_q  <= s1_final_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            out_dec_q   <= out_dec_d;
            out_tag_q   <= out_tag_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_ttable_lane u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .s1_en_i    (ld1_c),
            .s2_en_i    (ld2_c),
            .word_i     (bus.in_state[32*i +: 32]),
            .dec_i      (bus.in_dec),
            .s1_dec_i   (s1_dec_q),
            .s1_final_i (s1_final_q),
            .p_o        (bus.out_p[128*i +: 128])
        );
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_dec   = out_dec_q;
    assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_aes_ttable_pipe.sv
// Self-checking bench for aes_ttable_pipe; S-boxes and T-words are derived from GF(2^8) arithmetic.
module tb_aes_ttable_pipe;
    localparam int unsigned LANES = 4;
    localparam int unsigned TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    always #5 clk = ~clk;

    aes_ttable_pipe_if #(.LANES(LANES), .TAG_W(TAG_W)) bus ();

    aes_ttable_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Carry-less multiply then reduce by 0x11b from the top bit down.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] exp_lane(input logic [31:0] w, input bit dec, input bit fin);
        logic [127:0] res;
        logic [7:0]   b, s;
        logic [31:0]  t, rt;
        int           r;
        res = '0;
        for (int k = 0; k < 4; k++) begin
            b = 8'(w >> (24 - 8 * k));
            s = dec ? isb[b] : sb[b];
            if (fin)      t = {24'h0, s};
            else if (dec) t = {gmul(s, 8'd14), gmul(s, 8'd9), gmul(s, 8'd13), gmul(s, 8'd11)};
            else          t = {s, s, gmul(s, 8'd3), gmul(s, 8'd2)};
            r  = 8 * ((k + 1) % 4);
            rt = (t >> r) | (t << (32 - r));
            res[127 - 32 * k -: 32] = rt;
        end
        return res;
    endfunction

    function automatic logic [511:0] exp_p(input logic [127:0] st, input bit dec, input bit fin);
        logic [511:0] res;
        for (int i = 0; i < 4; i++) res[128 * i +: 128] = exp_lane(st[32 * i +: 32], dec, fin);
        return res;
    endfunction

    task automatic set_final(input bit f);
`ifdef AES_TTAB_FINAL_EN
        bus.in_final = f;
`else
        if (f) $display("note: in_final requested without AES_TTAB_FINAL_EN");
`endif
    endtask

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.in_state  = '0;
        bus.in_dec    = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        set_final(1'b0);
    endtask

    // Presents one transfer on an idle pipe and returns at the cycle it should be on the output.
    task automatic send_one(input logic [127:0] st, input bit dec, input logic [3:0] tag,
                            input bit fin, output bit early_ov);
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_state = st; bus.in_dec = dec; bus.in_tag = tag; set_final(fin);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; set_final(1'b0);
        @(negedge clk); early_ov = bus.out_valid;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_p !== '0) begin errors++; $display("FAIL reset_out_p got=%h exp=0", bus.out_p); end
        checks++; if (bus.out_tag !== '0 || bus.out_dec !== 1'b0) begin errors++; $display("FAIL reset_tag_dec got=%h/%b exp=0/0", bus.out_tag, bus.out_dec); end
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fwd_zero();
        bit ev;
        logic [127:0] lane_exp;
        lane_exp = {32'hc66363a5, 32'ha5c66363, 32'h63a5c663, 32'h6363a5c6};
        send_one('0, 1'b0, 4'h5, 1'b0, ev);
        checks++; if (ev !== 1'b0) begin errors++; $display("FAIL fwd0_latency_early got=%b exp=0", ev); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fwd0_out_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_tag !== 4'h5 || bus.out_dec !== 1'b0) begin errors++; $display("FAIL fwd0_tag_dec got=%h/%b exp=5/0", bus.out_tag, bus.out_dec); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_p[128 * i +: 128] !== lane_exp) begin errors++; $display("FAIL fwd0_lane%0d got=%h exp=%h", i, bus.out_p[128 * i +: 128], lane_exp); end
        end
    endtask

    task automatic test_dec_zero();
        bit ev;
        send_one('0, 1'b1, 4'ha, 1'b0, ev);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_dec !== 1'b1 || bus.out_tag !== 4'ha) begin errors++; $display("FAIL dec0_ctrl got=%b/%b/%h exp=1/1/a", bus.out_valid, bus.out_dec, bus.out_tag); end
        checks++; if (bus.out_p[31:0] !== 32'h51f4a750) begin errors++; $display("FAIL dec0_word3 got=%h exp=51f4a750", bus.out_p[31:0]); end
        checks++; if (bus.out_p[127:96] !== 32'h5051f4a7) begin errors++; $display("FAIL dec0_word0 got=%h exp=5051f4a7", bus.out_p[127:96]); end
        checks++; if (bus.out_p !== exp_p('0, 1'b1, 1'b0)) begin errors++; $display("FAIL dec0_model got=%h exp=%h", bus.out_p, exp_p('0, 1'b1, 1'b0)); end
    endtask

    task automatic test_fwd_one();
        bit ev;
        logic [127:0] st;
        logic [127:0] lane_exp;
        st = {$urandom, $urandom, $urandom, 32'h00000001};
        lane_exp = {32'hc66363a5, 32'ha5c66363, 32'h63a5c663, 32'h7c7c84f8};
        send_one(st, 1'b0, 4'h3, 1'b0, ev);
        checks++; if (bus.out_p[127:0] !== lane_exp) begin errors++; $display("FAIL fwd1_lane0 got=%h exp=%h", bus.out_p[127:0], lane_exp); end
        checks++; if (bus.out_p !== exp_p(st, 1'b0, 1'b0)) begin errors++; $display("FAIL fwd1_model got=%h exp=%h", bus.out_p, exp_p(st, 1'b0, 1'b0)); end
    endtask

`ifdef AES_TTAB_FINAL_EN
    task automatic test_final();
        bit ev;
        logic [127:0] lane_exp;
        lane_exp = {32'h63000000, 32'h00630000, 32'h00006300, 32'h00000063};
        send_one('0, 1'b0, 4'h6, 1'b1, ev);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_p[128 * i +: 128] !== lane_exp) begin errors++; $display("FAIL final_lane%0d got=%h exp=%h", i, bus.out_p[128 * i +: 128], lane_exp); end
        end
    endtask
`endif

    // Streaming scoreboard: sweep mode walks every byte value in both modes, else random traffic.
    task automatic test_stream(input int n, input bit sweep);
        logic [511:0] q_p [$];
        logic         q_dec [$];
        logic [3:0]   q_tag [$];
        logic [127:0] st;
        bit           dec, fin;
        int           sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        while (got < n && cyc < n * 8 + 50) begin
            @(posedge clk); #1;
            cyc++;
            fin = 1'b0;
            if (sweep) begin
                for (int j = 0; j < 16; j++) st[127 - 8 * j -: 8] = 8'((sent % 16) * 16 + j);
                dec = (sent >= 16);
                bus.in_valid  = (sent < n);
                bus.out_ready = 1'b1;
            end else begin
                st  = {$urandom, $urandom, $urandom, $urandom};
                dec = 1'($urandom_range(0, 1));
`ifdef AES_TTAB_FINAL_EN
                fin = ($urandom_range(0, 3) == 0);
`endif
                bus.in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.in_state = st; bus.in_dec = dec; bus.in_tag = 4'(sent); set_final(fin);
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q_p.size() == 0) begin
                    errors++; $display("FAIL stream_spurious_output tag=%h exp=none", bus.out_tag);
                end else begin
                    if (bus.out_p !== q_p[0]) begin errors++; $display("FAIL stream_p got=%h exp=%h", bus.out_p, q_p[0]); end
                    checks++;
                    if (bus.out_dec !== q_dec[0]) begin errors++; $display("FAIL stream_dec got=%b exp=%b", bus.out_dec, q_dec[0]); end
                    checks++;
                    if (bus.out_tag !== q_tag[0]) begin errors++; $display("FAIL stream_tag got=%h exp=%h", bus.out_tag, q_tag[0]); end
                    void'(q_p.pop_front()); void'(q_dec.pop_front()); void'(q_tag.pop_front());
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q_p.push_back(exp_p(st, dec, fin)); q_dec.push_back(dec); q_tag.push_back(4'(sent));
                sent++;
            end
        end
        drive_idle();
        checks++; if (got != n) begin errors++; $display("FAIL stream_timeout got=%0d exp=%0d", got, n); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [127:0] st [8];
        logic [511:0] q_p [$];
        logic [3:0]   q_tag [$];
        logic [511:0] snap_p;
        logic [3:0]   snap_tag;
        logic         snap_dec;
        bit           prev_stall, exp_rdy;
        int           sent, got, cyc, stalls, extra;
        for (int i = 0; i < 8; i++) st[i] = {$urandom, $urandom, $urandom, $urandom};
        sent = 0; got = 0; cyc = 0; stalls = 0; prev_stall = 1'b0;
        snap_p = '0; snap_tag = '0; snap_dec = 1'b0;
        while (got < 8 && cyc < 60) begin
            @(posedge clk); #1;
            bus.in_valid  = (sent < 8);
            bus.in_state  = st[sent % 8];
            bus.in_dec    = sent[0];
            bus.in_tag    = 4'(sent);
            bus.out_ready = !(cyc >= 4 && cyc < 7);
            cyc++;
            @(negedge clk);
            exp_rdy = !(bus.out_valid && !bus.out_ready);
            checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, exp_rdy); end
            if (prev_stall) begin
                checks++;
                if (bus.out_p !== snap_p || bus.out_tag !== snap_tag || bus.out_dec !== snap_dec || bus.out_valid !== 1'b1) begin
                    errors++; $display("FAIL b2b_stall_hold tag got=%h exp=%h valid=%b", bus.out_tag, snap_tag, bus.out_valid);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            if (prev_stall) stalls++;
            snap_p = bus.out_p; snap_tag = bus.out_tag; snap_dec = bus.out_dec;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q_p.size() == 0 || bus.out_p !== q_p[0] || bus.out_tag !== q_tag[0]) begin
                    errors++; $display("FAIL b2b_output tag got=%h exp=%h", bus.out_tag, (q_tag.size() != 0) ? q_tag[0] : 4'hx);
                end
                if (q_p.size() != 0) begin void'(q_p.pop_front()); void'(q_tag.pop_front()); end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q_p.push_back(exp_p(st[sent], sent[0], 1'b0)); q_tag.push_back(4'(sent));
                sent++;
            end
        end
        drive_idle();
        checks++; if (got != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", got); end
        checks++; if (stalls != 3) begin errors++; $display("FAIL b2b_stall_cycles got=%0d exp=3", stalls); end
        extra = 0;
        repeat (4) begin @(negedge clk); if (bus.out_valid) extra++; end
        checks++; if (extra != 0) begin errors++; $display("FAIL b2b_duplicate got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] st;
        bit ev;
        int ghosts;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_state = {4{$urandom}}; bus.in_tag = 4'h1; bus.in_dec = 1'b0;
        @(posedge clk); #1;
        bus.in_state = {4{$urandom}}; bus.in_tag = 4'h2; bus.in_dec = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_inflight got=%b exp=1", bus.out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_p !== '0) begin errors++; $display("FAIL rstmid_clear valid=%b p=%h exp=0/0", bus.out_valid, bus.out_p); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        ghosts = 0;
        repeat (3) begin @(negedge clk); if (bus.out_valid) ghosts++; end
        checks++; if (ghosts != 0) begin errors++; $display("FAIL rstmid_ghost got=%0d exp=0", ghosts); end
        st = {$urandom, $urandom, $urandom, $urandom};
        send_one(st, 1'b1, 4'h9, 1'b0, ev);
        checks++; if (ev !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_tag !== 4'h9) begin errors++; $display("FAIL rstmid_after_ctrl got=%b/%b/%h exp=0/1/9", ev, bus.out_valid, bus.out_tag); end
        checks++; if (bus.out_p !== exp_p(st, 1'b1, 1'b0)) begin errors++; $display("FAIL rstmid_after_p got=%h exp=%h", bus.out_p, exp_p(st, 1'b1, 1'b0)); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        build_tables();
        test_reset();
        test_fwd_zero();
        test_dec_zero();
        test_fwd_one();
`ifdef AES_TTAB_FINAL_EN
        test_final();
`endif
        test_stream(32, 1'b1);
        test_stream(200, 1'b0);
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
